// File: rtl/usb_ep_in_packetizer_if.sv
// Response/payload channel between the IN packetizer and the packet transmitter.
interface usb_ep_in_packetizer_if;
  logic       respValid;
  logic       respReady;
  logic       respHandshakePID;
  logic [1:0] respPacketID;
  logic       txDataValid;
  logic [7:0] txData;
  logic       txReady;
  logic       txPacketEnd;

  modport master (
    output respValid, respHandshakePID, respPacketID,
    output txDataValid, txData, txPacketEnd,
    input  respReady, txReady
  );

  modport slave (
    input  respValid, respHandshakePID, respPacketID,
    input  txDataValid, txData, txPacketEnd,
    output respReady, txReady
  );
endinterface

// File: rtl/usb_ep_in_packetizer.sv
// IN endpoint packetizer: answers IN tokens with NAK/STALL or one data packet drained
// from the endpoint FIFO, tracks DATA0/DATA1 and closes the FIFO pop transaction.
module usb_ep_in_packetizer #(
  parameter int unsigned MAX_PACKET_SIZE = 64
) (
  input  logic                   clk12_i,
  input  logic                   rst_n_i,
  input  logic                   inTokenValid_i,
  input  logic                   stall_i,
  input  logic                   resetDataToggle_i,
  input  logic                   hostAck_i,
  input  logic                   hostTimeout_i,
  usb_ep_in_packetizer_if.master tx_if,
  input  logic                   fifoDataAvailable_i,
  input  logic [7:0]             fifoData_i,
  output logic                   fifoPopData_o,
  output logic                   fifoPopTransDone_o,
  output logic                   fifoPopTransSuccess_o
);

  localparam int unsigned CNT_WID = $clog2(MAX_PACKET_SIZE + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HS, ST_DPID, ST_SEND, ST_FETCH, ST_END, ST_WAIT_ACK
  } state_e;

  state_e               state_q, state_d;
  logic                 toggle_q, toggle_d;
  logic [CNT_WID-1:0]   cnt_q, cnt_d;
  logic [1:0]           hs_pid_q, hs_pid_d;

  logic                 resp_valid;
  logic                 resp_hs;
  logic [1:0]           resp_pid;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_end;

  // State and datapath registers
  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      toggle_q <= 1'b0;
      cnt_q    <= '0;
      hs_pid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      toggle_q <= toggle_d;
      cnt_q    <= cnt_d;
      hs_pid_q <= hs_pid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (inTokenValid_i) begin
          state_d = (stall_i || !fifoDataAvailable_i) ? ST_HS : ST_DPID;
        end
      end
      ST_HS:    if (tx_if.respReady) state_d = ST_IDLE;
      ST_DPID:  if (tx_if.respReady) state_d = ST_SEND;
      ST_SEND:  if (tx_if.txReady)   state_d = ST_FETCH;
      ST_FETCH: begin
        // FIFO flags already reflect the pop issued in SEND
        if (cnt_q == CNT_WID'(MAX_PACKET_SIZE) || !fifoDataAvailable_i) begin
          state_d = ST_END;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_END:      state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (hostAck_i || hostTimeout_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: byte counter, latched handshake PID, data toggle
  always_comb begin
    toggle_d = toggle_q;
    cnt_d    = cnt_q;
    hs_pid_d = hs_pid_q;
    if (state_q == ST_IDLE && inTokenValid_i) begin
      hs_pid_d = stall_i ? 2'b11 : 2'b10;
    end
    if (state_q == ST_DPID && tx_if.respReady) begin
      cnt_d = '0;
    end
    if (state_q == ST_SEND && tx_if.txReady) begin
      cnt_d = cnt_q + CNT_WID'(1);
    end
    if (state_q == ST_WAIT_ACK && hostAck_i) begin
      toggle_d = ~toggle_q;
    end
    // Toggle reset overrides a same-cycle ACK flip
    if (resetDataToggle_i) begin
      toggle_d = 1'b0;
    end
  end

  // Output decode from registered state and live handshake inputs
  always_comb begin
    resp_valid            = 1'b0;
    resp_hs               = 1'b0;
    resp_pid              = 2'b00;
    tx_valid              = 1'b0;
    tx_data               = 8'h00;
    tx_end                = 1'b0;
    fifoPopData_o         = 1'b0;
    fifoPopTransDone_o    = 1'b0;
    fifoPopTransSuccess_o = 1'b0;
    unique case (state_q)
      ST_HS: begin
        resp_valid = 1'b1;
        resp_hs    = 1'b1;
        resp_pid   = hs_pid_q;
      end
      ST_DPID: begin
        resp_valid = 1'b1;
        resp_pid   = toggle_q ? 2'b10 : 2'b00;
      end
      ST_SEND: begin
        tx_valid      = 1'b1;
        tx_data       = fifoData_i;
        fifoPopData_o = tx_if.txReady;
      end
      ST_END: tx_end = 1'b1;
      ST_WAIT_ACK: begin
        fifoPopTransDone_o    = hostAck_i | hostTimeout_i;
        fifoPopTransSuccess_o = hostAck_i;
      end
      default: ;
    endcase
  end

  assign tx_if.respValid        = resp_valid;
  assign tx_if.respHandshakePID = resp_hs;
  assign tx_if.respPacketID     = resp_pid;
  assign tx_if.txDataValid      = tx_valid;
  assign tx_if.txData           = tx_data;
  assign tx_if.txPacketEnd      = tx_end;

endmodule

// File: tb/tb_usb_ep_in_packetizer.sv
// Self-checking bench for usb_ep_in_packetizer: FIFO emulator, transaction-level model, per-cycle monitor.
module tb_usb_ep_in_packetizer;

  localparam int MPS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       tok = 1'b0, stall = 1'b0, rtog = 1'b0, ack = 1'b0, tmo = 1'b0;
  logic       favail;
  logic [7:0] fdata;
  logic       pop, done, succ;

  usb_ep_in_packetizer_if tx_if ();

  usb_ep_in_packetizer #(.MAX_PACKET_SIZE(MPS)) dut (
    .clk12_i              (clk),
    .rst_n_i              (rst_n),
    .inTokenValid_i       (tok),
    .stall_i              (stall),
    .resetDataToggle_i    (rtog),
    .hostAck_i            (ack),
    .hostTimeout_i        (tmo),
    .tx_if                (tx_if.master),
    .fifoDataAvailable_i  (favail),
    .fifoData_i           (fdata),
    .fifoPopData_o        (pop),
    .fifoPopTransDone_o   (done),
    .fifoPopTransSuccess_o(succ)
  );

  // FIFO emulator: speculative read pointer, committed read pointer, rollback on failure
  logic [7:0] mem [0:8191];
  int wr_ptr = 0, rd_spec = 0, rd_com = 0;
  assign favail = (rd_spec < wr_ptr);
  assign fdata  = favail ? mem[rd_spec] : 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_spec <= wr_ptr;
      rd_com  <= wr_ptr;
    end else begin
      if (pop) rd_spec <= rd_spec + 1;
      if (done) begin
        if (succ) rd_com <= rd_spec;
        else      rd_spec <= rd_com;
      end
    end
  end

  // Transaction-level model: committed byte position, data toggle, expected response
  int         mdl_rd = 0;
  bit         mdl_tog = 1'b0;
  int         exp_kind = 0;          // 0 none, 1 NAK, 2 STALL, 3 DATA
  logic [1:0] exp_pid = 2'b00;
  logic [7:0] exp_bytes[$];
  int         idx = 0;
  bit         exp_done = 1'b0, exp_succ = 1'b0;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({tx_if.respValid, tx_if.respHandshakePID, tx_if.respPacketID, tx_if.txDataValid,
                tx_if.txData, tx_if.txPacketEnd, pop, done, succ});
  endfunction

  // Expected response to an IN token under the current stall/FIFO/toggle situation
  task automatic predict();
    int avail, n;
    avail = wr_ptr - mdl_rd;
    exp_bytes.delete();
    idx = 0;
    if (stall) begin
      exp_kind = 2; exp_pid = 2'b11;
    end else if (avail == 0) begin
      exp_kind = 1; exp_pid = 2'b10;
    end else begin
      exp_kind = 3; exp_pid = mdl_tog ? 2'b10 : 2'b00;
      n = (avail > MPS) ? MPS : avail;
      for (int i = 0; i < n; i++) exp_bytes.push_back(mem[mdl_rd + i]);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("outs_in_reset", all_outs(), 0);
    end else begin
      if (tx_if.respValid) begin
        chk("resp_handshake", tx_if.respHandshakePID, (exp_kind != 3) ? 1 : 0);
        chk("resp_pid", tx_if.respPacketID, exp_pid);
      end
      if (tx_if.txDataValid && exp_kind == 3 && idx < exp_bytes.size()) begin
        chk("tx_byte", tx_if.txData, exp_bytes[idx]);
        chk("pop_vs_ready", pop, tx_if.txReady);
        if (tx_if.txReady) idx++;
      end else begin
        chk("tx_valid_unexpected", tx_if.txDataValid, 0);
        chk("pop_unexpected", pop, 0);
      end
      if (tx_if.txPacketEnd) chk("pkt_len", idx, exp_bytes.size());
      chk("trans_done", done, exp_done);
      if (done) chk("trans_success", succ, exp_succ);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic do_token();
    predict();
    tok = 1'b1;
    tick();
    tok = 1'b0;
  endtask

  task automatic accept_resp();
    bit got = 1'b0, acc;
    for (int c = 0; c < 200; c++) begin
      acc = tx_if.respValid && ($urandom_range(2) != 0);
      tx_if.respReady = acc;
      tick();
      if (acc) begin got = 1'b1; break; end
    end
    tx_if.respReady = 1'b0;
    chk("resp_seen", got, 1);
  endtask

  task automatic send_payload();
    bit seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (tx_if.txPacketEnd) begin seen = 1'b1; break; end
      tx_if.txReady = tx_if.txDataValid && ($urandom_range(3) != 0);
      tok = ($urandom_range(7) == 0);
      tick();
    end
    tx_if.txReady = 1'b0;
    tok = 1'b0;
    chk("pkt_end_seen", seen, 1);
  endtask

  // kind: 0 ACK, 1 timeout, 2 both in one cycle; rt: toggle reset in the same cycle
  task automatic finish(input int kind, input bit rt);
    tick();
    repeat ($urandom_range(3)) tick();
    ack  = (kind != 1);
    tmo  = (kind != 0);
    rtog = rt;
    exp_done = 1'b1;
    exp_succ = ack;
    if (ack) begin
      mdl_rd  += exp_bytes.size();
      mdl_tog = ~mdl_tog;
    end
    if (rt) mdl_tog = 1'b0;
    tick();
    ack = 1'b0; tmo = 1'b0; rtog = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic run_packet(input int kind, input bit rt);
    accept_resp();
    if (exp_kind == 3) begin
      send_payload();
      finish(kind, rt);
    end
  endtask

  task automatic pulse_rtog();
    rtog = 1'b1;
    mdl_tog = 1'b0;
    tick();
    rtog = 1'b0;
  endtask

  initial begin
    bit seen;
    tx_if.respReady = 1'b0;
    tx_if.txReady   = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_outs_after_reset", all_outs(), 0);

    // Empty FIFO -> NAK
    do_token();
    chk("pin_nak_kind", exp_kind, 1);
    chk("pin_nak_pid", exp_pid, 2'b10);
    run_packet(0, 1'b0);

    // Three bytes as DATA0, ACK flips toggle
    push(8'hA1); push(8'hB2); push(8'hC3);
    do_token();
    chk("pin_t2_pid", exp_pid, 2'b00);
    chk("pin_t2_len", exp_bytes.size(), 3);
    run_packet(0, 1'b0);
    chk("pin_t2_toggle", mdl_tog, 1);

    // 70 bytes split 64 + 6
    pulse_rtog();
    for (int i = 0; i < 70; i++) push(8'(i));
    do_token();
    chk("pin_t3a_pid", exp_pid, 2'b00);
    chk("pin_t3a_len", exp_bytes.size(), 64);
    run_packet(0, 1'b0);
    do_token();
    chk("pin_t3b_pid", exp_pid, 2'b10);
    chk("pin_t3b_len", exp_bytes.size(), 6);
    chk("pin_t3b_first", exp_bytes[0], 8'd64);
    run_packet(0, 1'b0);

    // Timeout rolls back; same bytes resent with the same PID
    push(8'hA1); push(8'hB2); push(8'hC3);
    do_token();
    chk("pin_t4a_pid", exp_pid, 2'b00);
    run_packet(1, 1'b0);
    do_token();
    chk("pin_t4b_pid", exp_pid, 2'b00);
    chk("pin_t4b_len", exp_bytes.size(), 3);
    chk("pin_t4b_first", exp_bytes[0], 8'hA1);
    run_packet(0, 1'b0);

    // Stall with data, then toggle reset while DATA1 pending
    for (int i = 0; i < 5; i++) push(8'($urandom));
    stall = 1'b1;
    do_token();
    chk("pin_t5_stall_pid", exp_pid, 2'b11);
    run_packet(0, 1'b0);
    stall = 1'b0;
    chk("pin_t5_pending_toggle", mdl_tog, 1);
    pulse_rtog();
    do_token();
    chk("pin_t5_pid", exp_pid, 2'b00);
    chk("pin_t5_len", exp_bytes.size(), 5);
    run_packet(0, 1'b0);

    // Reset while sending with txReady high
    push(8'h11); push(8'h22); push(8'h33);
    do_token();
    accept_resp();
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (tx_if.txDataValid) begin seen = 1'b1; break; end
      tick();
    end
    chk("t6_send_reached", seen, 1);
    tx_if.txReady = 1'b1;
    #1;
    chk("t6_pop_before_reset", pop, 1);
    rst_n = 1'b0;
    exp_kind = 0;
    exp_bytes.delete();
    #1;
    chk("t6_outs_at_reset", all_outs(), 0);
    tx_if.txReady = 1'b0;
    mdl_rd  = wr_ptr;
    mdl_tog = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    push(8'hA1); push(8'hB2); push(8'hC3);
    do_token();
    chk("pin_t6_pid", exp_pid, 2'b00);
    run_packet(0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(3) != 0) begin
        int n = $urandom_range(80);
        for (int i = 0; i < n; i++) push(8'($urandom));
      end
      stall = ($urandom_range(5) == 0);
      if ($urandom_range(4) == 0) pulse_rtog();
      if ($urandom_range(4) == 0) begin
        ack = $urandom_range(1);
        tmo = ~ack;
        tick();
        ack = 1'b0; tmo = 1'b0;
      end
      do_token();
      run_packet(int'($urandom_range(2)), ($urandom_range(5) == 0));
      stall = 1'b0;
      repeat ($urandom_range(2)) tick();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
